// File: rtl/mm_bus_arb.sv
// rtl/mm_bus_arb.sv - two-core arbiter onto one shared memory-mapped bus with lock and read return
module mm_bus_arb #(
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c1_addr,
    input  logic              c0_re,
    input  logic              c1_re,
    input  logic              c0_we,
    input  logic              c1_we,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic [DATA_W-1:0] c1_wdata,
    input  logic              c0_lock,
    input  logic              c1_lock,
    output logic              c0_stall,
    output logic              c1_stall,
    output logic [DATA_W-1:0] c0_rdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c0_rvld,
    output logic              c1_rvld,
    output logic [DATA_W-1:0] mm_addr,
    output logic              mm_re,
    output logic              mm_we,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic [DATA_W-1:0] mm_rdata,
    output logic [1:0]        gnt
);

    localparam int LCNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCK_MAX - 1);
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state;
    logic              lg;
    logic [LCNT_W-1:0] lcnt;
    logic              rvld0_q;
    logic              rvld1_q;

    logic req0, req1, held0, held1, win0, win1, rd0, rd1;

    always_comb begin
        req0  = c0_re | c0_we;
        req1  = c1_re | c1_we;
        held0 = (state == OWN0) && c0_lock;
        held1 = (state == OWN1) && c1_lock;
        win0  = 1'b0;
        win1  = 1'b0;
        // A held lock shuts the other core out even when the owner is silent.
        if (held0) begin
            win0 = req0;
        end else if (held1) begin
            win1 = req1;
        end else if (req0 && req1) begin
            win0 = lg;
            win1 = ~lg;
        end else begin
            win0 = req0;
            win1 = req1;
        end
        if (rst) begin
            win0 = 1'b0;
            win1 = 1'b0;
        end
        rd0 = win0 & c0_re & ~c0_we;
        rd1 = win1 & c1_re & ~c1_we;
    end

    always_comb begin
        mm_addr  = '0;
        mm_wdata = '0;
        mm_re    = 1'b0;
        mm_we    = 1'b0;
        if (win0) begin
            mm_addr  = c0_addr;
            mm_wdata = c0_wdata;
            mm_we    = c0_we;
            mm_re    = rd0;
        end else if (win1) begin
            mm_addr  = c1_addr;
            mm_wdata = c1_wdata;
            mm_we    = c1_we;
            mm_re    = rd1;
        end
    end

    assign gnt      = rst ? 2'b00 : {held1 | win1, held0 | win0};
    assign c0_stall = req0 & ~win0 & ~rst;
    assign c1_stall = req1 & ~win1 & ~rst;
    // Masking by rst kills a return pulse that lands in the reset cycle.
    assign c0_rvld  = rvld0_q & ~rst;
    assign c1_rvld  = rvld1_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lg       <= 1'b1;
            lcnt     <= '0;
            c0_rdata <= '0;
            c1_rdata <= '0;
            rvld0_q  <= 1'b0;
            rvld1_q  <= 1'b0;
        end else begin
            if (win0 | win1) lg <= win1;
            rvld0_q <= rd0;
            rvld1_q <= rd1;
            if (rd0) c0_rdata <= mm_rdata;
            if (rd1) c1_rdata <= mm_rdata;
            // lcnt counts locked cycles already spent, including the acquiring one.
            if (held0 || held1) begin
                if (lcnt == LCNT_LAST) begin
                    state <= IDLE;
                    lcnt  <= '0;
                end else begin
                    lcnt <= lcnt + LCNT_ONE;
                end
            end else if (win0 && c0_lock) begin
                state <= OWN0;
                lcnt  <= LCNT_ONE;
            end else if (win1 && c1_lock) begin
                state <= OWN1;
                lcnt  <= LCNT_ONE;
            end else begin
                state <= IDLE;
                lcnt  <= '0;
            end
        end
    end

endmodule
